// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source encoding for the common-data-bus arbiter.
// Widths mirror the DATA_WIDTH / ROB_IDX_WIDTH defines used across the core.
package cdb_arbiter_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ROB_IDX_WIDTH  = 4;
  localparam int CDB_FIFO_DEPTH = 2;

  typedef enum logic {
    SRC_RS  = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side result ports and the CDB broadcast, bundled for the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core's.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W    = DATA_WIDTH,
  parameter int ROB_IDX_W = ROB_IDX_WIDTH
) ();

  logic                 rs_in_en;
  logic [ROB_IDX_W-1:0] rs_rob_idx_in;
  logic [DATA_W-1:0]    rs_val_in;
  logic                 rs_stall;

  logic                 lsb_in_en;
  logic [ROB_IDX_W-1:0] lsb_rob_idx_in;
  logic [DATA_W-1:0]    lsb_val_in;
  logic                 lsb_stall;

  logic                 cdb_out_en;
  logic [ROB_IDX_W-1:0] cdb_rob_idx_out;
  logic [DATA_W-1:0]    cdb_val_out;

  modport slave (
    input  rs_in_en, rs_rob_idx_in, rs_val_in,
    input  lsb_in_en, lsb_rob_idx_in, lsb_val_in,
    output rs_stall, lsb_stall,
    output cdb_out_en, cdb_rob_idx_out, cdb_val_out
  );

  modport master (
    output rs_in_en, rs_rob_idx_in, rs_val_in,
    output lsb_in_en, lsb_rob_idx_in, lsb_val_in,
    input  rs_stall, lsb_stall,
    input  cdb_out_en, cdb_rob_idx_out, cdb_val_out
  );

endinterface

// File: rtl/cdb_fifo.sv
// Per-source tag+value FIFO. The head output falls through to the live input
// when empty, so an idle source reaches the CDB without a queueing cycle.
module cdb_fifo #(
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 4,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 in_en,
  input  logic [ROB_IDX_W-1:0] in_tag,
  input  logic [DATA_W-1:0]    in_val,
  input  logic                 grant_in,
  output logic                 head_valid_o,
  output logic [ROB_IDX_W-1:0] head_tag_o,
  output logic [DATA_W-1:0]    head_val_o,
  output logic                 full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ROB_IDX_W-1:0] tag_mem_q [DEPTH];
  logic [DATA_W-1:0]    val_mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic empty;
  logic pop;
  logic bypass;
  logic push;

  assign empty  = (cnt_q == '0);
  assign full_o = (cnt_q == CNT_W'(DEPTH));

  assign head_valid_o = !empty || in_en;
  assign head_tag_o   = empty ? in_tag : tag_mem_q[rd_ptr_q];
  assign head_val_o   = empty ? in_val : val_mem_q[rd_ptr_q];

  // A granted head is the stored entry unless the FIFO is empty, in which case
  // the grant consumed the live input and it must not also be queued.
  assign pop    = rdy_in && !flush_in && grant_in && !empty;
  assign bypass = grant_in && empty;
  assign push   = rdy_in && !flush_in && in_en && !bypass && !full_o;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (rdy_in) begin
      if (flush_in) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        cnt_d    = '0;
      end else begin
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    if (rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count guards every read, so
  // stale entries are never observed and the array can map to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= in_tag;
      val_mem_q[wr_ptr_q] <= in_val;
    end
  end

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (rst_in) !(rdy_in && !flush_in && in_en && full_o)
  );

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin merge of RS and LSB results onto a single registered CDB
// broadcast; flushes on roll_back and freezes while rdy_in is low.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W    = DATA_WIDTH,
  parameter int ROB_IDX_W = ROB_IDX_WIDTH,
  parameter int DEPTH     = CDB_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         roll_back,
  cdb_arbiter_if.slave bus
);

  logic                 rs_cand_valid, lsb_cand_valid;
  logic [ROB_IDX_W-1:0] rs_cand_tag, lsb_cand_tag;
  logic [DATA_W-1:0]    rs_cand_val, lsb_cand_val;
  logic                 rs_grant, lsb_grant;
  logic                 rs_full, lsb_full;

  src_e                 rr_last_q, rr_last_d;
  logic                 cdb_en_q, cdb_en_d;
  logic [ROB_IDX_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]    cdb_val_q, cdb_val_d;

  cdb_fifo #(
    .DATA_W    (DATA_W),
    .ROB_IDX_W (ROB_IDX_W),
    .DEPTH     (DEPTH)
  ) u_rs_fifo (
    .clk          (clk),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .flush_in     (roll_back),
    .in_en        (bus.rs_in_en),
    .in_tag       (bus.rs_rob_idx_in),
    .in_val       (bus.rs_val_in),
    .grant_in     (rs_grant),
    .head_valid_o (rs_cand_valid),
    .head_tag_o   (rs_cand_tag),
    .head_val_o   (rs_cand_val),
    .full_o       (rs_full)
  );

  cdb_fifo #(
    .DATA_W    (DATA_W),
    .ROB_IDX_W (ROB_IDX_W),
    .DEPTH     (DEPTH)
  ) u_lsb_fifo (
    .clk          (clk),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .flush_in     (roll_back),
    .in_en        (bus.lsb_in_en),
    .in_tag       (bus.lsb_rob_idx_in),
    .in_val       (bus.lsb_val_in),
    .grant_in     (lsb_grant),
    .head_valid_o (lsb_cand_valid),
    .head_tag_o   (lsb_cand_tag),
    .head_val_o   (lsb_cand_val),
    .full_o       (lsb_full)
  );

  // On a tie the source that did not win last time is granted.
  always_comb begin
    rs_grant  = 1'b0;
    lsb_grant = 1'b0;
    if (rdy_in && !roll_back) begin
      if (rs_cand_valid && lsb_cand_valid) begin
        rs_grant  = (rr_last_q == SRC_LSB);
        lsb_grant = (rr_last_q == SRC_RS);
      end else begin
        rs_grant  = rs_cand_valid;
        lsb_grant = lsb_cand_valid;
      end
    end
  end

  always_comb begin
    rr_last_d = rr_last_q;
    cdb_en_d  = cdb_en_q;
    cdb_tag_d = cdb_tag_q;
    cdb_val_d = cdb_val_q;
    if (rdy_in) begin
      cdb_en_d = rs_grant || lsb_grant;
      if (roll_back) begin
        rr_last_d = SRC_LSB;
      end else if (rs_grant) begin
        rr_last_d = SRC_RS;
        cdb_tag_d = rs_cand_tag;
        cdb_val_d = rs_cand_val;
      end else if (lsb_grant) begin
        rr_last_d = SRC_LSB;
        cdb_tag_d = lsb_cand_tag;
        cdb_val_d = lsb_cand_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      rr_last_q <= SRC_LSB;
      cdb_en_q  <= 1'b0;
      cdb_tag_q <= '0;
      cdb_val_q <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      cdb_en_q  <= cdb_en_d;
      cdb_tag_q <= cdb_tag_d;
      cdb_val_q <= cdb_val_d;
    end
  end

  assign bus.rs_stall        = rs_full;
  assign bus.lsb_stall       = lsb_full;
  assign bus.cdb_out_en      = cdb_en_q;
  assign bus.cdb_rob_idx_out = cdb_tag_q;
  assign bus.cdb_val_out     = cdb_val_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, ties, contention with stalls,
// roll-back, pause and asynchronous reset, with hand-computed expectations.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic roll_back;

  int checks = 0;
  int errors = 0;

  cdb_arbiter_if #(.DATA_W(DW), .ROB_IDX_W(TW)) bus ();

  cdb_arbiter #(
    .DATA_W    (DW),
    .ROB_IDX_W (TW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .roll_back (roll_back),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rs_en, input logic [TW-1:0] rs_tag, input logic [DW-1:0] rs_val,
                       input logic lsb_en, input logic [TW-1:0] lsb_tag, input logic [DW-1:0] lsb_val);
    bus.rs_in_en       = rs_en;
    bus.rs_rob_idx_in  = rs_tag;
    bus.rs_val_in      = rs_val;
    bus.lsb_in_en      = lsb_en;
    bus.lsb_rob_idx_in = lsb_tag;
    bus.lsb_val_in     = lsb_val;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic expect_cdb(input string tag, input logic en, input logic [TW-1:0] t, input logic [DW-1:0] v);
    check({tag, ".en"},  64'(bus.cdb_out_en), 64'(en));
    check({tag, ".tag"}, 64'(bus.cdb_rob_idx_out), 64'(t));
    check({tag, ".val"}, 64'(bus.cdb_val_out), 64'(v));
  endtask

  task automatic expect_stall(input string tag, input logic rs, input logic lsb);
    check({tag, ".rs_stall"},  64'(bus.rs_stall), 64'(rs));
    check({tag, ".lsb_stall"}, 64'(bus.lsb_stall), 64'(lsb));
  endtask

  // RS tags are below 8 and carry 0x100+tag; LSB tags are 8 and up with 0x200+tag.
  task automatic cont_step(input logic rs_en, input logic [TW-1:0] rs_tag,
                           input logic lsb_en, input logic [TW-1:0] lsb_tag,
                           input logic [TW-1:0] exp_tag, input logic exp_rs_st, input logic exp_lsb_st);
    logic [DW-1:0] exp_val;
    drive(rs_en, rs_tag, 32'h100 + 32'(rs_tag), lsb_en, lsb_tag, 32'h200 + 32'(lsb_tag));
    tick();
    exp_val = (exp_tag < 4'd8) ? 32'h100 + 32'(exp_tag) : 32'h200 + 32'(exp_tag);
    expect_cdb("contention", 1'b1, exp_tag, exp_val);
    expect_stall("contention", exp_rs_st, exp_lsb_st);
  endtask

  initial begin
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    roll_back = 1'b0;
    idle();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    expect_cdb("reset", 1'b0, 4'd0, 32'd0);
    expect_stall("reset", 1'b0, 1'b0);
    check("reset.rr_last", 64'(dut.rr_last_q), 64'd1);
    rst_in = 1'b0;

    // First tie after reset: RS wins, LSB follows
    drive(1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB);
    tick();
    expect_cdb("tie.c1", 1'b1, 4'd1, 32'hA);
    idle();
    tick();
    expect_cdb("tie.c2", 1'b1, 4'd2, 32'hB);
    check("tie.rr_last", 64'(dut.rr_last_q), 64'd1);
    tick();
    check("tie.idle_en", 64'(bus.cdb_out_en), 64'd0);

    // Idle single source, one-cycle latency, then tag/value hold
    drive(1'b1, 4'd3, 32'h0000_0011, 1'b0, '0, '0);
    tick();
    expect_cdb("single", 1'b1, 4'd3, 32'h11);
    idle();
    tick();
    expect_cdb("single.idle", 1'b0, 4'd3, 32'h11);

    // Sustained contention; producers honour stall
    cont_step(1'b1, 4'd4, 1'b1, 4'd8,  4'd8,  1'b0, 1'b0);
    cont_step(1'b1, 4'd5, 1'b1, 4'd9,  4'd4,  1'b0, 1'b0);
    cont_step(1'b1, 4'd6, 1'b1, 4'd10, 4'd9,  1'b1, 1'b0);
    cont_step(1'b0, 4'd0, 1'b1, 4'd11, 4'd5,  1'b0, 1'b1);
    cont_step(1'b1, 4'd7, 1'b0, 4'd0,  4'd10, 1'b1, 1'b0);
    cont_step(1'b0, 4'd0, 1'b1, 4'd12, 4'd6,  1'b0, 1'b1);
    cont_step(1'b0, 4'd0, 1'b0, 4'd0,  4'd11, 1'b0, 1'b0);
    cont_step(1'b0, 4'd0, 1'b0, 4'd0,  4'd7,  1'b0, 1'b0);
    cont_step(1'b0, 4'd0, 1'b0, 4'd0,  4'd12, 1'b0, 1'b0);
    idle();
    tick();
    expect_cdb("contention.drained", 1'b0, 4'd12, 32'h20C);

    // Roll-back with two entries queued in the LSB FIFO
    drive(1'b1, 4'd1, 32'h301, 1'b1, 4'd9, 32'h309);
    tick();
    expect_cdb("rb.fill1", 1'b1, 4'd1, 32'h301);
    drive(1'b1, 4'd2, 32'h302, 1'b1, 4'd10, 32'h30A);
    tick();
    expect_cdb("rb.fill2", 1'b1, 4'd9, 32'h309);
    drive(1'b1, 4'd3, 32'h303, 1'b1, 4'd11, 32'h30B);
    tick();
    expect_cdb("rb.fill3", 1'b1, 4'd2, 32'h302);
    expect_stall("rb.full", 1'b0, 1'b1);
    drive(1'b1, 4'd4, 32'h304, 1'b0, '0, '0);
    roll_back = 1'b1;
    tick();
    roll_back = 1'b0;
    expect_cdb("rb.flush", 1'b0, 4'd2, 32'h302);
    expect_stall("rb.flush", 1'b0, 1'b0);
    drive(1'b1, 4'd5, 32'h355, 1'b0, '0, '0);
    tick();
    expect_cdb("rb.fresh", 1'b1, 4'd5, 32'h355);
    idle();
    tick();
    check("rb.no_stale", 64'(bus.cdb_out_en), 64'd0);

    // Pause for three cycles with both FIFOs holding one entry
    drive(1'b1, 4'd1, 32'h401, 1'b1, 4'd9, 32'h409);
    tick();
    expect_cdb("pause.pre1", 1'b1, 4'd9, 32'h409);
    drive(1'b1, 4'd2, 32'h402, 1'b1, 4'd10, 32'h40A);
    tick();
    expect_cdb("pause.pre2", 1'b1, 4'd1, 32'h401);
    rdy_in = 1'b0;
    drive(1'b1, 4'd7, 32'hDEAD, 1'b1, 4'd15, 32'hBEEF);
    tick();
    expect_cdb("pause.p1", 1'b1, 4'd1, 32'h401);
    tick();
    tick();
    expect_cdb("pause.p3", 1'b1, 4'd1, 32'h401);
    check("pause.rs_cnt",  64'(dut.u_rs_fifo.cnt_q), 64'd1);
    check("pause.lsb_cnt", 64'(dut.u_lsb_fifo.cnt_q), 64'd1);
    rdy_in = 1'b1;
    idle();
    tick();
    expect_cdb("pause.post1", 1'b1, 4'd10, 32'h40A);
    tick();
    expect_cdb("pause.post2", 1'b1, 4'd2, 32'h402);
    tick();
    check("pause.post_idle", 64'(bus.cdb_out_en), 64'd0);

    // Asynchronous reset between edges during traffic
    drive(1'b1, 4'd3, 32'h503, 1'b1, 4'd12, 32'h50C);
    tick();
    expect_cdb("areset.pre", 1'b1, 4'd12, 32'h50C);
    idle();
    #2;
    rst_in = 1'b1;
    #1;
    expect_cdb("areset", 1'b0, 4'd0, 32'd0);
    expect_stall("areset", 1'b0, 1'b0);
    check("areset.rr_last", 64'(dut.rr_last_q), 64'd1);
    check("areset.rs_cnt",  64'(dut.u_rs_fifo.cnt_q), 64'd0);
    #1;
    rst_in = 1'b0;
    tick();
    check("areset.no_stale", 64'(bus.cdb_out_en), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Merges the two result producers, the reservation station ALU and the load/store buffer, onto a single common data bus (CDB) broadcast, one result per cycle. Each producer has a small per-source FIFO; a round-robin arbiter picks one head per cycle and drives a registered broadcast. The ROB, RS and LSB then consume that broadcast instead of two separate result ports. The arbiter flushes on `roll_back` and freezes while `rdy_in` is low.

## Interface
Reset is asynchronous and active-high on `rst_in`; the block runs on the single clock `clk`.

Parameters:
- `DATA_W`, 32: result value width (matches `DATA_WIDTH`).
- `ROB_IDX_W`, 4: ROB tag width (matches `ROB_IDX_WIDTH`).
- `DEPTH`, 2: entries per source FIFO; power of two, at least 2.

Ports:
- `clk` in 1: clock.
- `rst_in` in 1: asynchronous active-high reset.
- `rdy_in` in 1: global enable; all state holds while it is low.
- `roll_back` in 1: misprediction flush.
- `rs_in_en` in 1: RS result valid this cycle.
- `rs_rob_idx_in` in ROB_IDX_W: RS result tag.
- `rs_val_in` in DATA_W: RS result value.
- `rs_stall` out 1: RS FIFO full; RS must not assert `rs_in_en`.
- `lsb_in_en` in 1: LSB result valid.
- `lsb_rob_idx_in` in ROB_IDX_W: LSB result tag.
- `lsb_val_in` in DATA_W: LSB result value.
- `lsb_stall` out 1: LSB FIFO full.
- `cdb_out_en` out 1: broadcast valid (registered).
- `cdb_rob_idx_out` out ROB_IDX_W: broadcast tag (registered).
- `cdb_val_out` out DATA_W: broadcast value (registered).

## Operation
- **Candidate per source.** The candidate is the FIFO head if the FIFO is non-empty, otherwise the same-cycle input if `*_in_en` is high (bypass).
- **Grant rule.**
  - Only one source has a candidate: that source is granted.
  - Both have candidates: the source other than `rr_last` is granted.
  - `rr_last` (0 = RS, 1 = LSB) updates to the granted source. It holds when nothing is granted.
- **Output.** The granted entry is registered onto the `cdb_*` outputs. With no grant, `cdb_out_en` is 0 and the tag and value hold their old values.
- **FIFO update per source.**
  - Pop when the head is granted.
  - Push the input when `*_in_en` is high and the input was not consumed by bypass.
  - Push and pop can happen in the same cycle; the count is unchanged.
- **Order.** Per-source FIFO order is preserved. Results from the two sources may interleave.
- **Stall.** `*_stall` = (count == DEPTH), combinational from registered count. Asserting `*_in_en` while stalled is a protocol violation. The entry is dropped and a simulation assertion fires.
- **Roll-back.** On an edge with `rdy_in` and `roll_back` both high:
  - both FIFOs empty (pointers and counts go to 0);
  - same-cycle inputs are discarded;
  - `cdb_out_en` is 0 next cycle;
  - `rr_last` is set to 1.
- **Pause.** With `rdy_in` low, nothing changes: FIFOs, pointers, `rr_last` and outputs all hold, and inputs are ignored.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

## Timing
- **Reset values.** `cdb_out_en`=0, `cdb_rob_idx_out`=0, `cdb_val_out`=0, `rs_stall`=0, `lsb_stall`=0, FIFOs empty, `rr_last`=1 (RS wins the first tie).
- **Latency.** An input to an idle arbiter appears on the CDB in the next cycle (1 cycle).
- **Queued entries.** An entry queued behind k older entries appears no earlier than k+1 cycles later.
- **Throughput.** One broadcast per cycle total. Under sustained contention each source gets every other cycle.
- **Stall timing.** Stall rises in the cycle after the push that fills the FIFO, and falls in the cycle after the pop that frees a slot.
- **Reset mid-operation.** Asynchronous reset clears all state immediately, including an in-flight broadcast.
- **Roll-back and stall.** `roll_back` has priority over pushes and grants in the same cycle. Stall is 0 in the cycle after a roll-back.

## Structure
- `DATA_WIDTH` and `ROB_IDX_WIDTH` come from the shared `param.v` defines; no new typedefs are needed.
- One sub-module, `cdb_fifo`: DEPTH-entry tag+value FIFO with a bypass head output, count, full flag and flush input. It is instanced twice, once for RS and once for LSB.
- Top level contains the round-robin grant logic, `rr_last` and the output register.

## Test plan
- **Idle single source.** RS sends (tag 3, 0x0000_0011) at cycle 0 → `cdb_out_en`=1 with tag 3 at cycle 1, then idle.
- **First tie after reset.** RS (tag 1, 0xA) and LSB (tag 2, 0xB) both at cycle 0 → cycle 1 broadcasts tag 1, cycle 2 broadcasts tag 2, `rr_last`=1.
- **Sustained contention, DEPTH=2.**
  - Stimulus: both sources fire every cycle.
  - Expected: tags alternate RS/LSB on the CDB.
  - `rs_stall`/`lsb_stall` assert once a FIFO holds 2 entries.
  - No entry is lost or reordered within a source.
- **Roll-back with queued entries.** Fill the LSB FIFO with 2 entries, assert `roll_back` for 1 cycle → next cycle `cdb_out_en`=0, both stalls 0; a fresh RS input is broadcast 1 cycle later.
- **Pause mid-stream.** Drop `rdy_in` for 3 cycles while both FIFOs are non-empty → outputs and counts are frozen; the broadcast sequence resumes unchanged afterwards.
- **Asynchronous reset.** Assert `rst_in` between clock edges during traffic → all outputs are 0 immediately, FIFOs are empty and `rr_last`=1.
